// File: rtl/seq_det_sched.sv
// Arbitrated serializer: grants one of four requesters, shifts its word MSB-first into an
// external sequence detector and counts detections. `define SEQ_DET_SCHED_RR_EN for round-robin.
module seq_det_sched #(
  parameter int WORD_W  = 8,
  parameter int DET_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [4*WORD_W-1:0]   req_data,
  output logic [3:0]            gnt,
  output logic                  busy,
  output logic                  sequence_out,
  output logic                  det_reset,
  input  logic                  detector_in,
  output logic                  done,
  output logic [1:0]            done_id,
  output logic [3:0]            match_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  localparam logic [4:0] K_FIRST      = 5'(DET_LAT);
  localparam logic [4:0] K_SHIFT_LAST = 5'(WORD_W - 1);
  localparam logic [4:0] K_LAST       = 5'(WORD_W + DET_LAT - 1);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [1:0]          id_q, id_d;
  logic [4:0]          k_q, k_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                seq_q, seq_d;
  logic                det_reset_q, det_reset_d;
  logic                done_q, done_d;
  logic [1:0]          done_id_q, done_id_d;
  logic [3:0]          match_cnt_q, match_cnt_d;
  logic [1:0]          win;
  logic                hit;

`ifdef SEQ_DET_SCHED_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    win   = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = 3; i >= 0; i--)
      if (req[i]) win = 2'(i);
  end
`endif

  // Detector output only counts once the first shifted bit can have reached it.
  assign hit = (k_q >= K_FIRST) && detector_in;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    id_d        = id_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    busy_d      = busy_q;
    seq_d       = 1'b0;
    det_reset_d = 1'b0;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
`ifdef SEQ_DET_SCHED_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: if (|req) begin
        word_d      = req_data[win*WORD_W +: WORD_W];
        id_d        = win;
        gnt_d       = 4'b0001 << win;
        busy_d      = 1'b1;
        det_reset_d = 1'b1;
        state_d     = CLEAR;
`ifdef SEQ_DET_SCHED_RR_EN
        ptr_d       = win + 2'd1;
`endif
      end
      CLEAR: begin
        seq_d   = word_q[WORD_W-1];
        word_d  = word_q << 1;
        k_d     = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT, DRAIN: begin
        cnt_d  = cnt_q + {3'b0, hit};
        k_d    = k_q + 5'd1;
        word_d = word_q << 1;
        if (k_q < K_SHIFT_LAST) begin
          seq_d   = word_q[WORD_W-1];
          state_d = SHIFT;
        end else if (k_q < K_LAST) begin
          state_d = DRAIN;
        end else begin
          done_d      = 1'b1;
          match_cnt_d = cnt_q + {3'b0, hit};
          done_id_d   = id_q;
          state_d     = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      id_q        <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      seq_q       <= 1'b0;
      det_reset_q <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
`ifdef SEQ_DET_SCHED_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      id_q        <= id_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      seq_q       <= seq_d;
      det_reset_q <= det_reset_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
`ifdef SEQ_DET_SCHED_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign gnt          = gnt_q;
  assign busy         = busy_q;
  assign sequence_out = seq_q;
  assign det_reset    = det_reset_q;
  assign done         = done_q;
  assign done_id      = done_id_q;
  assign match_cnt    = match_cnt_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: 1011 Moore detector in the loop, per-cycle transaction-level model.
module tb_seq_det_sched;
  localparam int W  = 8;
  localparam int DL = 1;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [4*W-1:0] req_data;
  logic [3:0]   gnt;
  logic         busy, sequence_out, det_reset, detector_in, done;
  logic [1:0]   done_id;
  logic [3:0]   match_cnt;

  int errors = 0;
  int checks = 0;

  seq_det_sched #(.WORD_W(W), .DET_LAT(DL)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .busy(busy), .sequence_out(sequence_out), .det_reset(det_reset),
    .detector_in(detector_in), .done(done), .done_id(done_id), .match_cnt(match_cnt)
  );

  always #5 clock = ~clock;

  // Overlapping-1011 Moore detector, cleared synchronously by det_reset.
  logic [3:0] hist;
  always_ff @(posedge clock or posedge reset)
    if (reset)          hist <= '0;
    else if (det_reset) hist <= '0;
    else                hist <= {hist[2:0], sequence_out};
  assign detector_in = (hist == 4'b1011);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int count_1011(input logic [W-1:0] w);
    int n = 0;
    for (int s = 0; s <= W - 4; s++)
      if (w[s +: 4] == 4'b1011) n++;
    return n;
  endfunction

  // Reference model: tracks one transaction by the cycle number of its grant.
  int cyc = 0, g = -100, next_idle = 0, ptr = 0, m_id_in = 0, pred_cnt = 0;
  logic [W-1:0] m_word = '0;
  logic [3:0] m_cnt = '0;
  logic [1:0] m_id = '0;
  int log_id[$];
  int log_cyc[$];

  always @(negedge clock) begin
    logic [3:0] e_gnt;
    logic e_busy, e_seq, e_det, e_done;
    int found;
    cyc++;
    if (reset) begin
      chk("reset_outs", {gnt, busy, sequence_out, det_reset, done, done_id, match_cnt}, '0);
      g = -100; m_cnt = '0; m_id = '0; ptr = 0; next_idle = cyc + 1;
    end else begin
      e_gnt  = (cyc == g) ? 4'(1 << m_id_in) : 4'b0;
      e_busy = (cyc >= g) && (cyc <= g + W + DL + 1);
      e_seq  = (cyc >= g + 1 && cyc <= g + W) ? m_word[W-1-(cyc-g-1)] : 1'b0;
      e_det  = (cyc == g);
      e_done = (cyc == g + W + DL + 1);
      if (e_done) begin
        m_cnt = 4'(pred_cnt);
        m_id  = 2'(m_id_in);
      end
      chk("gnt", gnt, e_gnt);
      chk("busy", busy, e_busy);
      chk("seq_out", sequence_out, e_seq);
      chk("det_reset", det_reset, e_det);
      chk("done", done, e_done);
      chk("match_cnt", match_cnt, m_cnt);
      chk("done_id", done_id, m_id);
      if (|gnt)
        for (int i = 0; i < 4; i++)
          if (gnt[i]) begin log_id.push_back(i); log_cyc.push_back(cyc); end
      if (cyc >= next_idle && |req) begin
        found = 0;
        for (int i = 0; i < 4; i++)
          if (!found && req[(ptr + i) % 4]) begin m_id_in = (ptr + i) % 4; found = 1; end
        g         = cyc + 1;
        m_word    = req_data[m_id_in*W +: W];
        pred_cnt  = count_1011(m_word);
        next_idle = g + W + DL + 2;
`ifdef SEQ_DET_SCHED_RR_EN
        ptr = (m_id_in + 1) % 4;
`endif
      end
    end
  end

  task automatic wait_gnt(output int c);
    c = -1;
    for (int i = 0; i < 40 && c < 0; i++) begin
      @(negedge clock);
      if (|gnt) c = cyc;
    end
    if (c < 0) chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 0; i < 40 && c < 0; i++) begin
      @(negedge clock);
      if (done) c = cyc;
    end
    if (c < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic serve(input int id, input logic [W-1:0] w, output int gc, output int dc);
    @(posedge clock); #1;
    req = 4'(1 << id);
    req_data[id*W +: W] = w;
    wait_gnt(gc);
    @(posedge clock); #1;
    req = '0;
    req_data = {$urandom, $urandom};
    wait_done(dc);
  endtask

  initial begin
    int gc, dc;
    reset = 1'b1; req = '0; req_data = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("post_reset", {gnt, busy, sequence_out, done, done_id, match_cnt}, '0);

    serve(0, 8'b10110110, gc, dc);
    chk("r031_latency", dc - gc, W + DL + 1);
    chk("r031_cnt", match_cnt, 2);
    chk("r031_id", done_id, 0);

    serve(2, 8'b00000000, gc, dc);
    chk("r032_cnt", match_cnt, 0);
    chk("r032_id", done_id, 2);

    serve(3, 8'b00000101, gc, dc);
    serve(3, 8'b10111011, gc, dc);
    chk("r033_cnt", match_cnt, 2);
    chk("r033_id", done_id, 3);

    @(posedge clock); #1;
    log_id.delete(); log_cyc.delete();
    req = 4'hF;
    repeat (62) @(posedge clock);
    #1 req = '0;
    repeat (15) @(posedge clock);
    chk("r034_n", log_id.size() >= 5, 1);
    for (int i = 0; i < 5 && i < log_id.size(); i++) begin
`ifdef SEQ_DET_SCHED_RR_EN
      chk("r034_id", log_id[i], i % 4);
`else
      chk("r034_id", log_id[i], 0);
`endif
      if (i > 0) chk("r034_gap", log_cyc[i] - log_cyc[i-1], W + DL + 3);
    end

    @(posedge clock); #1;
    req = 4'b0010;
    req_data = {$urandom, $urandom};
    wait_gnt(gc);
    req = '0;
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    #1 chk("r035_abort", {gnt, busy, sequence_out, det_reset, done, match_cnt}, '0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    serve(1, 8'b01011011, gc, dc);
    chk("r035_cnt", match_cnt, 2);
    chk("r035_id", done_id, 1);

    for (int i = 0; i < 600; i++) begin
      @(posedge clock); #1;
      req = 4'($urandom);
      req_data = {$urandom, $urandom};
    end
    req = '0;
    repeat (20) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 SHALL have parameter WORD_W, default 8, bits per request word, legal range 2..15.
REQ-002 SHALL have parameter DET_LAT, default 1, cycles from a bit on sequence_out to its effect on detector_in, legal range 1..3.
REQ-003 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  in  4  per-requester level request, held until granted.
REQ-006 SHALL have port req_data  in  4*WORD_W  word of requester i at bits [i*WORD_W +: WORD_W].
REQ-007 SHALL have port gnt  out  4  one-hot, one-cycle grant pulse.
REQ-008 SHALL have port busy  out  1  high from grant cycle through done cycle inclusive.
REQ-009 SHALL have port sequence_out  out  1  serial bit to the detector's sequence_in.
REQ-010 SHALL have port det_reset  out  1  one-cycle clear pulse to the detector's reset.
REQ-011 SHALL have port detector_in  in  1  detector's detector_out.
REQ-012 SHALL have port done  out  1  one-cycle result-valid pulse.
REQ-013 SHALL have port done_id  out  2  index of the requester whose result is on match_cnt.
REQ-014 SHALL have port match_cnt  out  4  number of detections for the served word.

Function
REQ-015 SHALL implement states IDLE, CLEAR, SHIFT, DRAIN, DONE; all outputs registered.
REQ-016 IDLE: with any req bit high, SHALL select a winner, latch its req_data slice and index, and enter CLEAR; with req all zero, SHALL stay in IDLE.
REQ-017 CLEAR (1 cycle): SHALL assert gnt[winner], det_reset=1, and sequence_out=0, then enter SHIFT.
REQ-018 SHIFT (WORD_W cycles, k=0..WORD_W-1): SHALL drive sequence_out = latched word bit [WORD_W-1-k], MSB first; det_reset=0.
REQ-019 DRAIN (DET_LAT cycles): SHALL drive sequence_out=0.
REQ-020 SHALL count cycles with detector_in=1 only for k in [DET_LAT, WORD_W+DET_LAT-1], counted from the first SHIFT cycle; all other cycles are ignored.
REQ-021 DONE (1 cycle): SHALL assert done with match_cnt and done_id valid, then enter IDLE.
REQ-022 match_cnt, done_id SHALL hold their last values until the next DONE.
REQ-023 Default latency: done SHALL rise WORD_W+DET_LAT+1 cycles after gnt (10 cycles with defaults).
REQ-024 Minimum grant-to-grant period: WORD_W+DET_LAT+3 cycles (12 cycles with defaults).
REQ-025 A req bit still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-026 req and req_data changes outside IDLE SHALL have no effect on the word in service.

Reset
REQ-027 On reset: state=IDLE; gnt=0, busy=0, sequence_out=0, det_reset=0, done=0, done_id=0, match_cnt=0; round-robin pointer=0.
REQ-028 Reset asserted mid-operation SHALL abort the word immediately, with no done pulse and no grant carried over.

Configuration
REQ-029 Macro SEQ_DET_SCHED_RR_EN defined: winner SHALL be the first requesting index at or after the pointer, modulo 4; after each grant, pointer = winner+1 mod 4.
REQ-030 Macro SEQ_DET_SCHED_RR_EN undefined: fixed priority, req[0] highest and req[3] lowest; pointer logic absent.

Verification
Bench setup: defaults; Moore model of the detector detecting overlapping 1011, reset by det_reset, DET_LAT=1.
REQ-031 req=4'b0001, word0=8'b10110110 -> gnt=4'b0001 for 1 cycle; done 10 cycles later; match_cnt=2, done_id=0.
REQ-032 req=4'b0100, word2=8'b00000000 -> match_cnt=0, done_id=2; sequence_out=0 throughout.
REQ-033 word=8'b10111011 after a prior word ending in 101 -> match_cnt=2; no carry-over detection, because det_reset clears the history.
REQ-034 RR_EN, req=4'b1111 held -> grants 0,1,2,3,0 at 12-cycle spacing; undefined -> grants 0,0,0.
REQ-035 reset asserted in SHIFT cycle k=4 -> outputs go to reset values at once, no done; after release with req=4'b0010 -> normal service of requester 1.
REQ-036 req_data changed during SHIFT -> result reflects the word latched at grant.
